de_morgan_sweeper: RTL and testbench

DE_MORGAN_SWEEPER -- requirements
Module: de_morgan_sweeper

---
 rtl/de_morgan_sweeper_if.sv | 42 ++++
 rtl/de_morgan_sweeper.sv | 143 ++++++++++++++
 tb/tb_de_morgan_sweeper.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/de_morgan_sweeper_if.sv
// Signal bundle between the De Morgan sweeper and the environment that hosts the DUT under test.
// start is a single-cycle request pulse with no ready/ack: it is honoured only while the sweeper is idle or done, otherwise dropped.
interface de_morgan_sweeper_if #(
    parameter int N = 2
);
    logic         start;
    logic [N-1:0] pattern;
    logic         dut_lhs;
    logic         dut_rhs;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic         err_valid;
    logic [N-1:0] first_err_pattern;

    modport master (
        input  start,
        input  dut_lhs,
        input  dut_rhs,
        output pattern,
        output busy,
        output done,
        output pass,
        output err_count,
        output err_valid,
        output first_err_pattern
    );

    modport slave (
        output start,
        output dut_lhs,
        output dut_rhs,
        input  pattern,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  err_valid,
        input  first_err_pattern
    );
endinterface

// File: rtl/de_morgan_sweeper.sv
// Exhaustively sweeps an N-bit pattern into a DUT and checks ~(&p) == |(~p) on both outputs.
// Each pattern is held SETTLE cycles, then checked for one cycle; mismatches are counted and the first is captured.
module de_morgan_sweeper #(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int GRAY   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    de_morgan_sweeper_if.master bus,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [N-1:0] IDX_LAST    = '1;
    localparam logic [N-1:0] IDX_ONE     = N'(1);
    localparam logic [N:0]   CNT_ONE     = (N+1)'(1);
    localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

    function automatic logic [N-1:0] map_pattern(input logic [N-1:0] idx);
        if (GRAY != 0) begin
            return idx ^ (idx >> 1);
        end
        return idx;
    endfunction

    state_t       state_q, state_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N-1:0] pattern_q, pattern_d;
    logic [N-1:0] first_err_q, first_err_d;
    logic [3:0]   settle_q, settle_d;
    logic [N:0]   err_count_q, err_count_d;
    logic         err_valid_q, err_valid_d;

    logic sweep_start;
    logic settle_last;
    logic idx_last;
    logic exp_out;
    logic mismatch;

    assign sweep_start = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign settle_last = (settle_q == SETTLE_LAST);
    assign idx_last    = (idx_q == IDX_LAST);
    assign exp_out     = ~(&pattern_q);
    // Both outputs wrong on the same pattern still counts as a single mismatch.
    assign mismatch    = (bus.dut_lhs != exp_out) || (bus.dut_rhs != exp_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_APPLY;
            S_APPLY: if (settle_last) state_d = S_CHECK;
            S_CHECK: state_d = idx_last ? S_DONE : S_APPLY;
            S_DONE:  if (bus.start) state_d = S_APPLY;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        pattern_d   = pattern_q;
        settle_d    = settle_q;
        err_count_d = err_count_q;
        err_valid_d = err_valid_q;
        first_err_d = first_err_q;
        if (sweep_start) begin
            idx_d       = '0;
            pattern_d   = map_pattern('0);
            settle_d    = '0;
            err_count_d = '0;
            err_valid_d = 1'b0;
            first_err_d = '0;
        end else if (state_q == S_APPLY) begin
            settle_d = settle_last ? 4'd0 : settle_q + 4'd1;
        end else if (state_q == S_CHECK) begin
            if (mismatch) begin
                err_count_d = err_count_q + CNT_ONE;
                if (!err_valid_q) begin
                    err_valid_d = 1'b1;
                    first_err_d = pattern_q;
                end
            end
            // On the last index the pattern is left alone so it holds through DONE.
            if (!idx_last) begin
                idx_d     = idx_q + IDX_ONE;
                pattern_d = map_pattern(idx_q + IDX_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            pattern_q   <= '0;
            settle_q    <= '0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            first_err_q <= '0;
        end else begin
            idx_q       <= idx_d;
            pattern_q   <= pattern_d;
            settle_q    <= settle_d;
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            first_err_q <= first_err_d;
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.pass = 1'b0;
        case (state_q)
            S_APPLY, S_CHECK: bus.busy = 1'b1;
            S_DONE: begin
                bus.done = 1'b1;
                bus.pass = (err_count_q == '0);
            end
            default: ;
        endcase
    end

    assign bus.pattern           = pattern_q;
    assign bus.err_count         = err_count_q;
    assign bus.err_valid         = err_valid_q;
    assign bus.first_err_pattern = first_err_q;
    assign state_o               = state_q;

endmodule

// File: tb/tb_de_morgan_sweeper.sv
// Directed bench for de_morgan_sweeper: binary, Gray and N=3/SETTLE=3 instances, fault, restart and reset cases.
module tb_de_morgan_sweeper;

    logic clk;
    logic rst_n;
    logic fault0;
    logic glitch2;
    logic [1:0] st0, st1, st2;
    logic [1:0] gray_tab [4];
    int checks;
    int errors;

    de_morgan_sweeper_if #(.N(2)) if0 ();
    de_morgan_sweeper_if #(.N(2)) if1 ();
    de_morgan_sweeper_if #(.N(3)) if2 ();

    de_morgan_sweeper #(.N(2), .SETTLE(1), .GRAY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master), .state_o(st0)
    );
    de_morgan_sweeper #(.N(2), .SETTLE(1), .GRAY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .state_o(st1)
    );
    de_morgan_sweeper #(.N(3), .SETTLE(3), .GRAY(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.master), .state_o(st2)
    );

    // DUT models: u0 can have lhs stuck at 0, u2 gets inverted outputs outside its CHECK cycles.
    assign if0.dut_lhs = fault0 ? 1'b0 : ~(&if0.pattern);
    assign if0.dut_rhs = |(~if0.pattern);
    assign if1.dut_lhs = ~(&if1.pattern);
    assign if1.dut_rhs = |(~if1.pattern);
    assign if2.dut_lhs = (~(&if2.pattern)) ^ glitch2;
    assign if2.dut_rhs = (|(~if2.pattern)) ^ glitch2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        gray_tab[0] = 2'd0;
        gray_tab[1] = 2'd1;
        gray_tab[2] = 2'd3;
        gray_tab[3] = 2'd2;
        fault0      = 1'b0;
        glitch2     = 1'b0;
        if0.start   = 1'b0;
        if1.start   = 1'b0;
        if2.start   = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pattern", 32'(if0.pattern), 0);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_done", 32'(if0.done), 0);
        chk("rst_pass", 32'(if0.pass), 0);
        chk("rst_err_count", 32'(if0.err_count), 0);
        chk("rst_err_valid", 32'(if0.err_valid), 0);
        chk("rst_first_err", 32'(if0.first_err_pattern), 0);
        chk("rst_state", 32'(st0), 0);
        chk("rst_u2_pattern", 32'(if2.pattern), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold_state", 32'(st0), 0);
        chk("idle_hold_busy", 32'(if0.busy), 0);

        // Scenario 1: binary sweep, correct DUT
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s1_pattern", 32'(if0.pattern), 32'(k / 2));
            chk("s1_busy", 32'(if0.busy), 1);
            chk("s1_done", 32'(if0.done), 0);
            @(negedge clk);
        end
        chk("s1_done_end", 32'(if0.done), 1);
        chk("s1_busy_end", 32'(if0.busy), 0);
        chk("s1_pass", 32'(if0.pass), 1);
        chk("s1_err_count", 32'(if0.err_count), 0);
        chk("s1_err_valid", 32'(if0.err_valid), 0);
        chk("s1_pattern_hold", 32'(if0.pattern), 3);

        // Scenario 2: Gray sweep
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s2_pattern", 32'(if1.pattern), 32'(gray_tab[k / 2]));
            chk("s2_busy", 32'(if1.busy), 1);
            @(negedge clk);
        end
        chk("s2_done", 32'(if1.done), 1);
        chk("s2_pass", 32'(if1.pass), 1);
        chk("s2_pattern_hold", 32'(if1.pattern), 2);

        // Scenario 3 + ignored start while busy: lhs stuck at 0, restart from DONE
        fault0    = 1'b1;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s3_pattern", 32'(if0.pattern), 32'(k / 2));
            chk("s3_done", 32'(if0.done), 0);
            if (k == 0) begin
                chk("s3_clr_err_count", 32'(if0.err_count), 0);
                chk("s3_clr_err_valid", 32'(if0.err_valid), 0);
            end
            if (k == 2) begin
                chk("s3_first_count", 32'(if0.err_count), 1);
                chk("s3_first_valid", 32'(if0.err_valid), 1);
            end
            if (k == 3) if0.start = 1'b1;
            if (k == 5) if0.start = 1'b0;
            @(negedge clk);
        end
        chk("s3_done_end", 32'(if0.done), 1);
        chk("s3_err_count", 32'(if0.err_count), 3);
        chk("s3_first_err", 32'(if0.first_err_pattern), 0);
        chk("s3_err_valid", 32'(if0.err_valid), 1);
        chk("s3_pass", 32'(if0.pass), 0);

        // Scenario 6: corrected DUT, start from DONE clears the error record
        fault0    = 1'b0;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk("s6_clr_err_count", 32'(if0.err_count), 0);
        chk("s6_clr_err_valid", 32'(if0.err_valid), 0);
        chk("s6_clr_first_err", 32'(if0.first_err_pattern), 0);
        chk("s6_busy", 32'(if0.busy), 1);
        repeat (8) @(negedge clk);
        chk("s6_done", 32'(if0.done), 1);
        chk("s6_pass", 32'(if0.pass), 1);
        chk("s6_err_count", 32'(if0.err_count), 0);

        // Scenario 4: N=3 SETTLE=3, DUT inputs corrupted except during CHECK
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            glitch2 = ((k % 4) != 3);
            chk("s4_pattern", 32'(if2.pattern), 32'(k / 4));
            chk("s4_busy", 32'(if2.busy), 1);
            chk("s4_done", 32'(if2.done), 0);
            if (k == 3) chk("s4_check_state", 32'(st2), 2);
            @(negedge clk);
        end
        glitch2 = 1'b0;
        chk("s4_done_end", 32'(if2.done), 1);
        chk("s4_pass", 32'(if2.pass), 1);
        chk("s4_err_count", 32'(if2.err_count), 0);
        chk("s4_pattern_hold", 32'(if2.pattern), 7);

        // Scenario 5: asynchronous reset mid-APPLY, then start on first edge after release
        fault0    = 1'b1;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("s5_pre_pattern", 32'(if0.pattern), 1);
        chk("s5_pre_err_count", 32'(if0.err_count), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_pattern", 32'(if0.pattern), 0);
        chk("s5_rst_busy", 32'(if0.busy), 0);
        chk("s5_rst_done", 32'(if0.done), 0);
        chk("s5_rst_err_count", 32'(if0.err_count), 0);
        chk("s5_rst_err_valid", 32'(if0.err_valid), 0);
        chk("s5_rst_first_err", 32'(if0.first_err_pattern), 0);
        chk("s5_rst_state", 32'(st0), 0);
        fault0 = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s5_pattern", 32'(if0.pattern), 32'(k / 2));
            chk("s5_busy", 32'(if0.busy), 1);
            @(negedge clk);
        end
        chk("s5_done", 32'(if0.done), 1);
        chk("s5_pass", 32'(if0.pass), 1);
        chk("s5_err_count", 32'(if0.err_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
